clock_set_ctrl: RTL and testbench

//  Controller that sequences the hours/minutes/seconds time counter. Generates
//  the count-enable tick from CLK100MHZ and runs a set-mode FSM driven by

---
 rtl/clock_set_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// Time-set controller: count-enable prescaler plus a set-mode FSM that edits hours/minutes/seconds.
// Optional display blink generation is enabled by defining BLINK_EN.
module clock_set_ctrl #(
    parameter int unsigned DIV        = 100_000_000,
    parameter int unsigned BLINK_HALF = 25_000_000
) (
    input  logic       CLK100MHZ,
    input  logic       reset_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic [7:0] hours,
    input  logic [7:0] minutes,
    input  logic [7:0] seconds,
    output logic       tick,
    output logic       load,
    output logic [7:0] newHours,
    output logic [7:0] newMinutes,
    output logic [7:0] newSeconds,
    output logic [1:0] set_field,
    output logic       blink
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_bad_div
        $error("clock_set_ctrl: DIV must be at least 2");
    end
    if (BLINK_HALF < 1) begin : g_bad_blink
        $error("clock_set_ctrl: BLINK_HALF must be at least 1");
    end

    typedef enum logic [2:0] {
        S_INIT,
        S_RUN,
        S_SET_H,
        S_SET_M,
        S_SET_S,
        S_COMMIT
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [PW-1:0]   r_presc, w_presc_nxt;
    logic            r_tick, w_tick_nxt;
    logic            r_load, w_load_nxt;
    logic [7:0]      r_h, r_m, r_s;
    logic [7:0]      w_h_nxt, w_m_nxt, w_s_nxt;
    logic [1:0]      r_field, w_field_nxt;
    logic            w_step;

    // Pressing inc and dec together cancels out
    assign w_step = btn_inc ^ btn_dec;

    function automatic logic [7:0] wrap_step(input logic [7:0] v, input logic [7:0] lim,
                                             input logic up);
        if (up) return (v == lim - 8'd1) ? 8'd0 : v + 8'd1;
        else    return (v == 8'd0) ? lim - 8'd1 : v - 8'd1;
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = '0;
        w_tick_nxt  = 1'b0;
        w_load_nxt  = 1'b0;
        w_h_nxt     = r_h;
        w_m_nxt     = r_m;
        w_s_nxt     = r_s;
        unique case (r_state)
            S_INIT: begin
                w_load_nxt  = 1'b1;
                w_h_nxt     = '0;
                w_m_nxt     = '0;
                w_s_nxt     = '0;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (btn_mode) begin
                    w_state_nxt = S_SET_H;
                    w_h_nxt     = (hours   >= 8'd24) ? '0 : hours;
                    w_m_nxt     = (minutes >= 8'd60) ? '0 : minutes;
                    w_s_nxt     = (seconds >= 8'd60) ? '0 : seconds;
                end else if (r_presc == PW'(DIV - 1)) begin
                    w_tick_nxt = 1'b1;
                end else begin
                    w_presc_nxt = r_presc + 1'b1;
                end
            end
            S_SET_H: begin
                if (btn_mode)    w_state_nxt = S_SET_M;
                else if (w_step) w_h_nxt = wrap_step(r_h, 8'd24, btn_inc);
            end
            S_SET_M: begin
                if (btn_mode)    w_state_nxt = S_SET_S;
                else if (w_step) w_m_nxt = wrap_step(r_m, 8'd60, btn_inc);
            end
            S_SET_S: begin
                if (btn_mode)    w_state_nxt = S_COMMIT;
                else if (w_step) w_s_nxt = wrap_step(r_s, 8'd60, btn_inc);
            end
            S_COMMIT: begin
                w_load_nxt  = 1'b1;
                w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_INIT;
        endcase

        unique case (w_state_nxt)
            S_SET_H: w_field_nxt = 2'd1;
            S_SET_M: w_field_nxt = 2'd2;
            S_SET_S: w_field_nxt = 2'd3;
            default: w_field_nxt = 2'd0;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_INIT;
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_load  <= 1'b0;
            r_h     <= '0;
            r_m     <= '0;
            r_s     <= '0;
            r_field <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_tick  <= w_tick_nxt;
            r_load  <= w_load_nxt;
            r_h     <= w_h_nxt;
            r_m     <= w_m_nxt;
            r_s     <= w_s_nxt;
            r_field <= w_field_nxt;
        end
    end

    assign tick       = r_tick;
    assign load       = r_load;
    assign newHours   = r_h;
    assign newMinutes = r_m;
    assign newSeconds = r_s;
    assign set_field  = r_field;

`ifdef BLINK_EN
    localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [BW-1:0] r_bcnt, w_bcnt_nxt;
    logic          r_blink, w_blink_nxt;
    logic          w_in_set, w_in_set_nxt;

    assign w_in_set     = (r_state == S_SET_H) || (r_state == S_SET_M) || (r_state == S_SET_S);
    assign w_in_set_nxt = (w_field_nxt != 2'd0);

    // Any entry, advance or effective edit restarts the blink phase visible
    always_comb begin
        w_bcnt_nxt  = '0;
        w_blink_nxt = 1'b0;
        if (w_in_set_nxt) begin
            if (!w_in_set || btn_mode || w_step) begin
                w_blink_nxt = 1'b1;
            end else if (r_bcnt == BW'(BLINK_HALF - 1)) begin
                w_blink_nxt = ~r_blink;
            end else begin
                w_bcnt_nxt  = r_bcnt + 1'b1;
                w_blink_nxt = r_blink;
            end
        end
    end

    always_ff @(posedge CLK100MHZ or negedge reset_n) begin
        if (!reset_n) begin
            r_bcnt  <= '0;
            r_blink <= 1'b0;
        end else begin
            r_bcnt  <= w_bcnt_nxt;
            r_blink <= w_blink_nxt;
        end
    end

    assign blink = r_blink;
`else
    assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Randomised scoreboard bench for clock_set_ctrl (DIV=4, BLINK_HALF=3); honours BLINK_EN.
module tb_clock_set_ctrl;

    localparam int unsigned DIV = 4;
    localparam int unsigned BH  = 3;
`ifdef BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_mode, btn_inc, btn_dec;
    logic [7:0] hours, minutes, seconds;
    logic       tick, load, blink;
    logic [7:0] newHours, newMinutes, newSeconds;
    logic [1:0] set_field;

    always #5 clk = ~clk;

    clock_set_ctrl #(.DIV(DIV), .BLINK_HALF(BH)) dut (
        .CLK100MHZ (clk),
        .reset_n   (reset_n),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .btn_dec   (btn_dec),
        .hours     (hours),
        .minutes   (minutes),
        .seconds   (seconds),
        .tick      (tick),
        .load      (load),
        .newHours  (newHours),
        .newMinutes(newMinutes),
        .newSeconds(newSeconds),
        .set_field (set_field),
        .blink     (blink)
    );

    typedef struct {
        bit tick;
        bit load;
        int h, m, s;
        int f;
        bit blink;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   pushes = 0;

    // Reference model: phase -1 = awaiting power-on load, 0 = running,
    // 1..3 = editing field (hours, minutes, seconds), 4 = awaiting commit load.
    int     phase;
    int     ed[3];
    int     lim[3] = '{24, 60, 60};
    longint n = 0;
    longint load_edge = 0;
    int     age;
    bit     m_tick, m_load;

    task automatic model_reset();
        phase = -1;
        ed = '{0, 0, 0};
        age = 0;
        m_tick = 0;
        m_load = 0;
    endtask

    task automatic model_edge(input bit bm, input bit bi, input bit bd,
                              input int hh, input int mm, input int ss);
        m_tick = 0;
        m_load = 0;
        if (phase == -1 || phase == 4) begin
            m_load = 1;
            if (phase == -1) ed = '{0, 0, 0};
            phase = 0;
            load_edge = n;
        end else if (phase == 0) begin
            if (bm) begin
                ed[0] = (hh >= 24) ? 0 : hh;
                ed[1] = (mm >= 60) ? 0 : mm;
                ed[2] = (ss >= 60) ? 0 : ss;
                phase = 1;
                age = 0;
            end else if ((n - load_edge) % DIV == 0) begin
                m_tick = 1;
            end
        end else begin
            if (bm) begin
                phase = phase + 1;
                age = 0;
            end else if (bi != bd) begin
                if (bi) ed[phase-1] = (ed[phase-1] + 1) % lim[phase-1];
                else    ed[phase-1] = (ed[phase-1] + lim[phase-1] - 1) % lim[phase-1];
                age = 0;
            end else begin
                age = age + 1;
            end
        end
    endtask

    task automatic push_expected();
        exp_t e;
        bit   editing;
        editing = (phase >= 1 && phase <= 3);
        e.tick  = m_tick;
        e.load  = m_load;
        e.h     = ed[0];
        e.m     = ed[1];
        e.s     = ed[2];
        e.f     = editing ? phase : 0;
        e.blink = BLINK_ON && editing && ((age / BH) % 2 == 0);
        q.push_back(e);
        pushes++;
    endtask

    task automatic check(input string nm, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp_v);
        end
    endtask

    function automatic int pick(input int l);
        int r;
        r = $urandom % 8;
        case (r)
            0: return 0;
            1: return l - 1;
            2: return l;
            3: return 255;
            default: return $urandom % l;
        endcase
    endfunction

    // Monitor: every cycle the DUT presents a full output set
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() == 0) begin
                if (pushes > 0) check("queue_underrun", 0, 1);
            end else begin
                e = q.pop_front();
                check("tick", int'(tick), int'(e.tick));
                check("load", int'(load), int'(e.load));
                check("newHours", int'(newHours), e.h);
                check("newMinutes", int'(newMinutes), e.m);
                check("newSeconds", int'(newSeconds), e.s);
                check("set_field", int'(set_field), e.f);
                check("blink", int'(blink), int'(e.blink));
            end
        end
    end

    initial begin
        int rst_hold;
        bit busy;
        reset_n  = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_dec  = 1'b0;
        hours    = 8'd0;
        minutes  = 8'd0;
        seconds  = 8'd0;
        rst_hold = 0;
        busy     = 1'b0;
        model_reset();
        repeat (3) begin
            @(posedge clk);
            #1;
            n++;
            push_expected();
        end
        reset_n = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            n++;
            if (reset_n) model_edge(btn_mode, btn_inc, btn_dec,
                                    int'(hours), int'(minutes), int'(seconds));
            if (c % 50 == 0) busy = $urandom_range(0, 1);
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) reset_n = 1'b1;
            end else if ($urandom % 400 == 0) begin
                reset_n  = 1'b0;
                rst_hold = $urandom_range(1, 3);
                model_reset();
            end
            if (busy) begin
                btn_mode = ($urandom % 8 == 0);
                btn_inc  = ($urandom % 2 == 0);
                btn_dec  = ($urandom % 2 == 0);
            end else begin
                btn_mode = ($urandom % 16 == 0);
                btn_inc  = ($urandom % 8 == 0);
                btn_dec  = ($urandom % 8 == 0);
            end
            hours   = 8'(pick(24));
            minutes = 8'(pick(60));
            seconds = 8'(pick(60));
            push_expected();
        end
        @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
